// File: rtl/prbs_pkg.sv
// Shared PRBS31 constants and types, used by both the generator and the checker
// so that both ends agree on the polynomial taps.
package prbs_pkg;

    localparam int LFSR_W    = 31;
    localparam int TAP_A     = 30;
    localparam int TAP_B     = 27;
    localparam int ERR_CNT_W = 16;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_t;

    // x^31 + x^28 + 1 with s[0] newest: the next bit is s[30] ^ s[27].
    function automatic logic prbs_predict(input logic [LFSR_W-1:0] s);
        return s[TAP_A] ^ s[TAP_B];
    endfunction

endpackage

// File: rtl/prbs31_window_mon.sv
// Loss-of-lock monitor: counts valid bits and errors over a fixed window and
// flags loss of lock when the error count reaches the threshold inside one window.
module prbs31_window_mon
    import prbs_pkg::*;
#(
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic bit_valid,
    input  logic bit_err,
    output logic lose
);

    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(LOSS_THRESH + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST = EW'(LOSS_THRESH - 1);

    logic [WW-1:0] win_cnt;
    logic [EW-1:0] err_cnt;
    logic          win_end;

    // Loss is decided on the error bit itself, so it beats a coincident window wrap.
    assign lose    = bit_valid && bit_err && (err_cnt == ERR_LAST);
    assign win_end = bit_valid && (win_cnt == WIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            err_cnt <= '0;
        end else if (restart || lose || win_end) begin
            win_cnt <= '0;
            err_cnt <= '0;
        end else if (bit_valid) begin
            win_cnt <= win_cnt + 1'b1;
            err_cnt <= err_cnt + EW'(bit_err);
        end
    end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 checker: self-synchronizes to the incoming stream, then free-runs its
// own LFSR and counts line errors, dropping lock on an error burst.
module prbs31_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_MATCHES = 64,
    parameter int WINDOW       = 256,
    parameter int LOSS_THRESH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 clear_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);
    localparam logic [4:0]    FILL_LAST  = 5'(LFSR_W);

    chk_state_t        state;
    logic [LFSR_W-1:0] s;
    logic [4:0]        fill_cnt;
    logic [MW-1:0]     match_cnt;
    logic              pred;
    logic              in_lock;
    logic              bit_err;
    logic              lose;

    assign pred    = prbs_predict(s);
    assign in_lock = (state == ST_LOCKED);
    assign bit_err = bit_valid && in_lock && (bit_in != pred);

    prbs31_window_mon #(
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_window_mon (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (!in_lock),
        .bit_valid (bit_valid),
        .bit_err   (bit_err),
        .lose      (lose)
    );

    // NOTE: all state here is flip-flops updated with non-blocking assignments,
    // so every branch sees the pre-edge values of s, counters and state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SEARCH;
            s         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;

            // Clear wins over an error counted in the same cycle.
            if (clear_cnt)
                err_count <= '0;
            else if (bit_err && (err_count != '1))
                err_count <= err_count + 1'b1;

            if (bit_valid) begin
                unique case (state)
                    ST_SEARCH: begin
                        s <= {s[LFSR_W-2:0], bit_in};
                        if (fill_cnt != FILL_LAST) begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end else if ((bit_in == pred) && (s != '0)) begin
                            if (match_cnt == MATCH_LAST) begin
                                state     <= ST_LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // Free-run on the prediction so a single line flip
                        // cannot corrupt later predictions.
                        s         <= {s[LFSR_W-2:0], pred};
                        err_pulse <= bit_err;
                        if (lose) begin
                            state     <= ST_SEARCH;
                            locked    <= 1'b0;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                        end
                    end
                    default: state <= ST_SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: a queue-based reference model predicts
// locked/err_pulse/err_count per cycle and a monitor compares after each edge.
module tb_prbs31_checker;

    localparam int LOCK_MATCHES = 64;
    localparam int WINDOW       = 256;
    localparam int LOSS_THRESH  = 16;

    logic        clk;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    prbs31_checker #(
        .LOCK_MATCHES (LOCK_MATCHES),
        .WINDOW       (WINDOW),
        .LOSS_THRESH  (LOSS_THRESH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit      lck;
        bit      pulse;
        int      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   pulse_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Sibling generator, seed 1: next = g[30]^g[27], shifted into g[0].
    logic [30:0] gen;
    function automatic bit gen_bit();
        bit b;
        b   = gen[30] ^ gen[27];
        gen = {gen[29:0], b};
        return b;
    endfunction

    // Reference model in terms of bit histories (oldest first) and integer counters.
    bit hist[$];
    bit refq[$];
    bit m_locked;
    int m_match, m_cnt, m_win, m_errs;

    task automatic model_reset();
        hist.delete();
        refq.delete();
        m_locked = 0;
        m_match  = 0;
        m_cnt    = 0;
        m_win    = 0;
        m_errs   = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr, output exp_t e);
        bit p, nz, err;
        e.pulse = 0;
        err     = 0;
        if (v && m_locked) begin
            p   = refq[0] ^ refq[3];
            err = (b != p);
            refq.push_back(p);
            void'(refq.pop_front());
        end
        if (clr) m_cnt = 0;
        else if (err && m_cnt != 65535) m_cnt++;
        if (v) begin
            if (!m_locked) begin
                if (hist.size() == 31) begin
                    p  = hist[0] ^ hist[3];
                    nz = 0;
                    foreach (hist[i]) if (hist[i]) nz = 1;
                    if (b == p && nz) begin
                        m_match++;
                        if (m_match == LOCK_MATCHES) begin
                            m_locked = 1;
                            m_match  = 0;
                            m_win    = 0;
                            m_errs   = 0;
                            refq     = hist;
                            refq.push_back(b);
                            void'(refq.pop_front());
                        end
                    end else begin
                        m_match = 0;
                    end
                end
                hist.push_back(b);
                if (hist.size() > 31) void'(hist.pop_front());
            end else begin
                e.pulse = err;
                m_win++;
                if (err) m_errs++;
                if (m_errs == LOSS_THRESH) begin
                    m_locked = 0;
                    m_match  = 0;
                    hist.delete();
                    m_win    = 0;
                    m_errs   = 0;
                end else if (m_win == WINDOW) begin
                    m_win  = 0;
                    m_errs = 0;
                end
            end
        end
        e.lck = m_locked;
        e.cnt = m_cnt;
    endtask

    // One cycle of stimulus; the generator advances only on valid bits.
    task automatic drive(input bit v, input bit flip, input bit clr, input bit zero);
        bit   b;
        exp_t e;
        @(negedge clk);
        if (v) b = zero ? 1'b0 : (gen_bit() ^ flip);
        else   b = 1'($urandom);
        bit_valid = v;
        bit_in    = b;
        clear_cnt = clr;
        model_step(v, b, clr, e);
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bit_valid = 1'b0;
        clear_cnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_pulse", {31'd0, err_pulse}, 32'd0);
        check("rst_count", {16'd0, err_count}, 32'd0);
        model_reset();
        gen = 31'd1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle's expected response is compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_locked", {31'd0, locked}, {31'd0, e.lck});
                check("sb_pulse", {31'd0, err_pulse}, {31'd0, e.pulse});
                check("sb_count", {16'd0, err_count}, e.cnt);
            end
            if (err_pulse === 1'b1) pulse_seen++;
        end
    end

    initial begin
        int p0;
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clear_cnt = 1'b0;
        gen       = 31'd1;
        model_reset();
        #1;
        check("init_locked", {31'd0, locked}, 32'd0);
        check("init_count", {16'd0, err_count}, 32'd0);

        // Clean stream: lock within 200 bits, no errors after 10000.
        do_reset();
        for (int i = 0; i < 200; i++) drive(1, 0, 0, 0);
        settle();
        check("lock_200", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 9800; i++) drive(1, 0, 0, 0);
        settle();
        check("clean_count", {16'd0, err_count}, 32'd0);

        // Single flipped bit: one pulse, count 1, still locked.
        p0 = pulse_seen;
        drive(1, 1, 0, 0);
        settle();
        check("flip_pulse", {31'd0, err_pulse}, 32'd1);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0);
        settle();
        check("flip_one_pulse", pulse_seen - p0, 32'd1);
        check("flip_count", {16'd0, err_count}, 32'd1);
        check("flip_locked", {31'd0, locked}, 32'd1);

        // Bring count to 5, then clear coincident with an error.
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 0);
            for (int i = 0; i < 9; i++) drive(1, 0, 0, 0);
        end
        settle();
        check("count_5", {16'd0, err_count}, 32'd5);
        drive(1, 1, 1, 0);
        settle();
        check("clr_count", {16'd0, err_count}, 32'd0);
        check("clr_pulse", {31'd0, err_pulse}, 32'd1);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0);

        // Async reset while locked.
        settle();
        check("pre_rst_locked", {31'd0, locked}, 32'd1);
        do_reset();

        // 16 errors within 80 bits after a fresh lock.
        for (int i = 0; i < 120; i++) drive(1, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) drive(1, 0, 0, 0);
            drive(1, 1, 0, 0);
        end
        settle();
        check("loss_locked", {31'd0, locked}, 32'd0);
        check("loss_count", {16'd0, err_count}, 32'd16);
        for (int i = 0; i < 200; i++) drive(1, 0, 0, 0);
        settle();
        check("relock", {31'd0, locked}, 32'd1);
        check("relock_count", {16'd0, err_count}, 32'd16);

        // All-zero input never locks.
        do_reset();
        for (int i = 0; i < 1000; i++) drive(1, 0, 0, 1);
        settle();
        check("zero_locked", {31'd0, locked}, 32'd0);
        check("zero_count", {16'd0, err_count}, 32'd0);

        // Valid every third cycle, random junk on invalid cycles.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            drive(0, 0, 0, 0);
            drive(0, 0, 0, 0);
            drive(1, 0, 0, 0);
        end
        settle();
        check("sparse_lock", {31'd0, locked}, 32'd1);
        p0 = pulse_seen;
        drive(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0);
            drive(0, 0, 0, 0);
            drive(1, 0, 0, 0);
        end
        settle();
        check("sparse_one_pulse", pulse_seen - p0, 32'd1);
        check("sparse_count", {16'd0, err_count}, 32'd1);

        // Random mix of valid gaps, flips and clears.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            drive(v, v && ($urandom_range(0, 39) == 0), v && ($urandom_range(0, 99) == 0), 0);
        end
        settle();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
